vga_mode_ctrl: RTL and testbench
================================

Name: vga_mode_ctrl

Overview:
Resolution-change sequencer for the VGA output path, in the sys_clk (100 MHz) domain. It debounces the board resolution switches and waits for a frame boundary on the driver's vertical sync. It then commits the new mode code to the VGA driver's sele input. Output stays blanked for a programmable number of frames around the switch, so the monitor never sees a torn or half-timed frame.

Parameters:
DEBOUNCE_CYCLES, 2000000, sys_clk cycles the switch value must be stable (20 ms)
BLANK_FRAMES, 2, frame boundaries to stay blanked after commit (>=1)
VS_TIMEOUT, 4000000, sys_clk cycles without a vsync fall treated as a frame boundary (40 ms)
SYNC_STAGES, 2, synchronizer depth for vga_vs (>=2)

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst_n  in  1  reset
sw_sele  in  4  raw resolution switches, asynchronous
vga_vs  in  1  vertical sync from VGA driver, active-low pulse, asynchronous to sys_clk
sele  out  4  committed mode code to VGA driver: 4'b0000 = 640x480, 4'b0001 = 800x600
blank  out  1  force RGB to zero downstream
busy  out  1  mode change in progress
mode_done  out  1  single-cycle pulse when sequence completes
frame_cnt  out  16  free-running count of frame boundaries

Behaviour:
- Reset: sys_rst_n, asynchronous, active-low; clock sys_clk. All outputs 0 in reset (sele=0000, blank=0, busy=0, mode_done=0, frame_cnt=0), state IDLE. Reset mid-sequence aborts at once; no completion pulse.
- sw_sele: 2-flop synchronizer per bit.
- Mode normalisation: req = (synced sw == 4'b0001) ? 4'b0001 : 4'b0000. Every other code maps to 640x480.
- vga_vs: passes through SYNC_STAGES flops plus one history flop.
- vs_fall: history=1 and synced=0. This fires SYNC_STAGES+1 cycles after the pin falls.
- Timeout counter:
  - Clears on every vs_fall and on every state entry.
  - When it reaches VS_TIMEOUT-1 it emits frame_evt and clears.
- frame_evt = vs_fall OR timeout. Both in the same cycle count as one event.
- frame_cnt: +1 on every vs_fall in any state; wraps 0xFFFF->0x0000. Timeouts do not count.
- FSM:
  - IDLE: if req != sele, latch cand=req, clear the debounce counter, go to DEBOUNCE.
  - DEBOUNCE, counter increments each cycle:
    - If req changes and req == sele: back to IDLE, no blanking.
    - If req changes to another value: reload cand and clear the counter.
    - If the counter reaches DEBOUNCE_CYCLES-1 with req == cand: go to WAIT_FRAME.
  - WAIT_FRAME: blank=1. On frame_evt: sele<=cand on the next clock edge, clear the frame counter, go to SETTLE.
  - SETTLE: blank=1. Count frame_evt. On the BLANK_FRAMES-th event go to IDLE; that cycle mode_done=1 and blank drops to 0.
- Switch changes during WAIT_FRAME/SETTLE are ignored; IDLE re-evaluates them the cycle after return.
- busy = (state != IDLE). blank is registered and high exactly in WAIT_FRAME and SETTLE.
- sele changes only at the WAIT_FRAME->SETTLE transition, never while blank=0.
- Counter widths: ceil(log2) of each parameter; no overflow possible.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=8, BLANK_FRAMES=2, VS_TIMEOUT=1000. vga_vs low for 4 cycles every 200 cycles unless stated.
1. Reset values:
   - Stimulus: assert reset with sw=0001.
   - Required: sele=0000, blank=0, busy=0, frame_cnt=0.
   - Then release reset, with no vs pulses.
   - Required: busy=1 within 4 cycles, blank=1 after debounce, sele=0001 after 1000 cycles (timeout).
2. Normal switch 0000->0001 with vs running:
   - busy rises 3 cycles after the switch edge; blank rises 8 cycles later.
   - sele=0001 one cycle after the first vs_fall; blank stays 1 through two further vs_fall events.
   - mode_done pulses exactly once, blank returns 0 and busy returns 0.
   - frame_cnt has advanced by 3 from the start of blanking.
3. Bounce: sw=0001 for 5 cycles, then back to 0000.
   - Required: blank never asserts, sele stays 0000, busy returns to 0, no mode_done.
4. Unsupported code: sele=0001 steady, then sw=0110.
   - Required: sequence runs and sele commits to 0000.
5. Lost vsync: vga_vs held high during a change.
   - Required: commit after 1000 cycles, completion 2000 cycles later, frame_cnt unchanged.
6. Reset mid-SETTLE: assert reset during SETTLE.
   - Required: sele=0000, blank=0, busy=0 immediately (asynchronous), mode_done stays 0.

Source files
------------

// File: rtl/vga_mode_ctrl_if.sv
// Signal bundle between the resolution-change sequencer and its surroundings:
// raw switches and driver vsync come in, committed mode and status go out.
interface vga_mode_ctrl_if;
  logic [3:0]  sw_sele;
  logic        vga_vs;
  logic [3:0]  sele;
  logic        blank;
  logic        busy;
  logic        mode_done;
  logic [15:0] frame_cnt;

  // Board / VGA driver side: drives switches and vsync, observes the sequencer
  modport master (
    output sw_sele,
    output vga_vs,
    input  sele,
    input  blank,
    input  busy,
    input  mode_done,
    input  frame_cnt
  );

  // Sequencer side
  modport slave (
    input  sw_sele,
    input  vga_vs,
    output sele,
    output blank,
    output busy,
    output mode_done,
    output frame_cnt
  );
endinterface

// File: rtl/vga_mode_ctrl.sv
// Resolution-change sequencer: debounces the resolution switches, waits for a
// frame boundary, commits the new mode code and keeps RGB blanked for a few
// frames so the monitor never sees a torn frame.
module vga_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int BLANK_FRAMES    = 2,
  parameter int VS_TIMEOUT      = 4000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  vga_mode_ctrl_if.slave  bus
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W  = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
  localparam int SET_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(VS_TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(BLANK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    WAIT_FRAME,
    SETTLE
  } state_t;

  state_t             state, state_next;
  logic [3:0]         sw_meta, sw_sync;
  logic [SYNC_STAGES-1:0] vs_sync;
  logic               vs_hist;
  logic [3:0]         req;
  logic               vs_fall, timeout, frame_evt;
  logic [TO_W-1:0]    to_cnt;
  logic [DEB_W-1:0]   deb_cnt, deb_next;
  logic [SET_W-1:0]   set_cnt, set_next;
  logic [3:0]         cand, cand_next;
  logic [3:0]         sele_q, sele_next;
  logic               blank_q, blank_next;
  logic               done_q, done_next;
  logic [15:0]        frame_q;

  // Bring the asynchronous switches and vsync into the sys_clk domain; vsync
  // idles high so its chain resets high to avoid a phantom falling edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sw_meta <= 4'b0000;
      sw_sync <= 4'b0000;
      vs_sync <= '1;
      vs_hist <= 1'b1;
    end else begin
      sw_meta <= bus.sw_sele;
      sw_sync <= sw_meta;
      vs_sync <= {vs_sync[SYNC_STAGES-2:0], bus.vga_vs};
      vs_hist <= vs_sync[SYNC_STAGES-1];
    end
  end

  // Only 800x600 is selectable explicitly; anything else falls back to 640x480.
  assign req       = (sw_sync == 4'b0001) ? 4'b0001 : 4'b0000;
  assign vs_fall   = vs_hist & ~vs_sync[SYNC_STAGES-1];
  assign timeout   = (to_cnt == TO_LAST);
  assign frame_evt = vs_fall | timeout;

  // Watchdog that manufactures a frame boundary when vsync goes missing;
  // restarts on every real boundary and whenever the FSM changes state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt <= '0;
    end else if (vs_fall || timeout || (state_next != state)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Free-running count of real vsync falls, wrapping naturally at 16 bits.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_q <= 16'h0000;
    end else if (vs_fall) begin
      frame_q <= frame_q + 16'h0001;
    end
  end

  // Next-state logic for the debounce / wait-for-frame / settle sequence.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    deb_next   = deb_cnt;
    set_next   = set_cnt;
    sele_next  = sele_q;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (req != sele_q) begin
          cand_next  = req;
          deb_next   = '0;
          state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (req != cand) begin
          if (req == sele_q) begin
            state_next = IDLE;
          end else begin
            cand_next = req;
            deb_next  = '0;
          end
        end else if (deb_cnt == DEB_LAST) begin
          state_next = WAIT_FRAME;
        end else begin
          deb_next = deb_cnt + 1'b1;
        end
      end
      WAIT_FRAME: begin
        if (frame_evt) begin
          sele_next  = cand;
          set_next   = '0;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (frame_evt) begin
          if (set_cnt == SET_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            set_next = set_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    blank_next = (state_next == WAIT_FRAME) || (state_next == SETTLE);
  end

  // Sequencer registers; blank and mode_done are registered from the next
  // state so they switch on the same edge as the state itself.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cand    <= 4'b0000;
      deb_cnt <= '0;
      set_cnt <= '0;
      sele_q  <= 4'b0000;
      blank_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cand    <= cand_next;
      deb_cnt <= deb_next;
      set_cnt <= set_next;
      sele_q  <= sele_next;
      blank_q <= blank_next;
      done_q  <= done_next;
    end
  end

  assign bus.sele      = sele_q;
  assign bus.blank     = blank_q;
  assign bus.busy      = (state != IDLE);
  assign bus.mode_done = done_q;
  assign bus.frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for the resolution-change sequencer with a small debounce,
// two blanking frames and a 1000-cycle vsync watchdog.
module tb_vga_mode_ctrl;

  logic sys_clk;
  logic sys_rst_n;
  bit   vs_run;
  int   vsPhase;
  int   nCompared;
  int   nMismatched;
  int   doneCount;
  int   blankCount;
  int   f0, d0, b0;
  bit   found;

  vga_mode_ctrl_if bus ();

  vga_mode_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .BLANK_FRAMES    (2),
    .VS_TIMEOUT      (1000),
    .SYNC_STAGES     (2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // 100 MHz clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // vsync source: low for 4 cycles every 200 cycles while enabled, else high
  initial begin
    bus.vga_vs = 1'b1;
    vsPhase    = 0;
    forever begin
      @(negedge sys_clk);
      if (vs_run) begin
        bus.vga_vs = (vsPhase < 4) ? 1'b0 : 1'b1;
        vsPhase    = (vsPhase == 199) ? 0 : vsPhase + 1;
      end else begin
        bus.vga_vs = 1'b1;
        vsPhase    = 0;
      end
    end
  end

  // Running tallies of completion pulses and blanked cycles
  always @(negedge sys_clk) begin
    if (bus.mode_done) doneCount = doneCount + 1;
    if (bus.blank) blankCount = blankCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared = nCompared + 1;
    if (obs !== exp) begin
      nMismatched = nMismatched + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sw);
    bus.sw_sele = sw;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  // Returns at the first sample where the vsync pin has just gone low
  task automatic waitVsFall(input string tag);
    logic prev;
    bit   hit;
    prev = bus.vga_vs;
    hit  = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      waitCycles(1);
      if (prev == 1'b1 && bus.vga_vs == 1'b0) hit = 1'b1;
      prev = bus.vga_vs;
    end
    checkOutput(tag, hit, 1);
  endtask

  task automatic waitBlankRise(input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      waitCycles(1);
      if (bus.blank) hit = 1'b1;
    end
    checkOutput(tag, hit, 1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      waitCycles(1);
      if (!bus.busy) hit = 1'b1;
    end
    checkOutput(tag, hit, 1);
  endtask

  task automatic pulseReset(input logic [3:0] sw);
    sys_rst_n = 1'b0;
    applyStimulus(sw);
    waitCycles(3);
    sys_rst_n = 1'b1;
    waitCycles(2);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    doneCount   = 0;
    blankCount  = 0;
    vs_run      = 1'b0;
    sys_rst_n   = 1'b0;
    applyStimulus(4'b0001);

    // 1: reset values, then watchdog-driven change with no vsync
    waitCycles(3);
    checkOutput("rst_sele", bus.sele, 4'b0000);
    checkOutput("rst_blank", bus.blank, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.mode_done, 0);
    checkOutput("rst_frame_cnt", bus.frame_cnt, 0);
    sys_rst_n = 1'b1;
    waitCycles(2);
    checkOutput("t1_busy_early", bus.busy, 0);
    waitCycles(1);
    checkOutput("t1_busy", bus.busy, 1);
    waitCycles(7);
    checkOutput("t1_blank_early", bus.blank, 0);
    waitCycles(1);
    checkOutput("t1_blank", bus.blank, 1);
    waitCycles(999);
    checkOutput("t1_sele_early", bus.sele, 4'b0000);
    waitCycles(1);
    checkOutput("t1_sele_commit", bus.sele, 4'b0001);
    waitIdle("t1_idle", 2100);
    checkOutput("t1_frame_cnt", bus.frame_cnt, 0);

    // 2: normal 0000 -> 0001 with vsync running
    vs_run = 1'b1;
    pulseReset(4'b0000);
    waitVsFall("t2_align");
    waitCycles(20);
    d0 = doneCount;
    applyStimulus(4'b0001);
    waitCycles(2);
    checkOutput("t2_busy_early", bus.busy, 0);
    waitCycles(1);
    checkOutput("t2_busy", bus.busy, 1);
    waitCycles(7);
    checkOutput("t2_blank_early", bus.blank, 0);
    waitCycles(1);
    checkOutput("t2_blank", bus.blank, 1);
    f0 = bus.frame_cnt;
    waitVsFall("t2_fall1");
    waitCycles(2);
    checkOutput("t2_sele_pre", bus.sele, 4'b0000);
    waitCycles(1);
    checkOutput("t2_sele_commit", bus.sele, 4'b0001);
    waitVsFall("t2_fall2");
    waitCycles(3);
    checkOutput("t2_blank_settle", bus.blank, 1);
    waitVsFall("t2_fall3");
    waitCycles(2);
    checkOutput("t2_busy_last", bus.busy, 1);
    waitCycles(1);
    checkOutput("t2_done", bus.mode_done, 1);
    checkOutput("t2_blank_off", bus.blank, 0);
    checkOutput("t2_busy_off", bus.busy, 0);
    checkOutput("t2_frame_adv", bus.frame_cnt, (f0 + 3) & 16'hFFFF);
    waitCycles(1);
    checkOutput("t2_done_pulse", bus.mode_done, 0);
    checkOutput("t2_done_count", doneCount - d0, 1);

    // 4: unsupported code from 800x600 commits 640x480
    waitVsFall("t4_align");
    waitCycles(20);
    d0 = doneCount;
    applyStimulus(4'b0110);
    waitCycles(5);
    checkOutput("t4_busy", bus.busy, 1);
    waitIdle("t4_idle", 1500);
    checkOutput("t4_sele", bus.sele, 4'b0000);
    checkOutput("t4_done_count", doneCount - d0, 1);

    // 3: bounce shorter than debounce window
    waitVsFall("t3_align");
    waitCycles(20);
    d0 = doneCount;
    b0 = blankCount;
    applyStimulus(4'b0001);
    waitCycles(5);
    applyStimulus(4'b0000);
    waitCycles(30);
    checkOutput("t3_blank_seen", blankCount - b0, 0);
    checkOutput("t3_sele", bus.sele, 4'b0000);
    checkOutput("t3_busy", bus.busy, 0);
    checkOutput("t3_done_count", doneCount - d0, 0);

    // 5: lost vsync during a change
    vs_run = 1'b0;
    waitCycles(10);
    f0 = bus.frame_cnt;
    applyStimulus(4'b0001);
    waitBlankRise("t5_blank");
    waitCycles(999);
    checkOutput("t5_sele_early", bus.sele, 4'b0000);
    waitCycles(1);
    checkOutput("t5_sele_commit", bus.sele, 4'b0001);
    waitCycles(1999);
    checkOutput("t5_busy_last", bus.busy, 1);
    waitCycles(1);
    checkOutput("t5_busy_off", bus.busy, 0);
    checkOutput("t5_done", bus.mode_done, 1);
    checkOutput("t5_frame_cnt", bus.frame_cnt, f0);

    // 6: asynchronous reset in the middle of SETTLE
    vs_run = 1'b1;
    pulseReset(4'b0000);
    waitVsFall("t6_align");
    waitCycles(20);
    applyStimulus(4'b0001);
    waitBlankRise("t6_blank");
    waitVsFall("t6_fall1");
    waitCycles(53);
    checkOutput("t6_in_settle", bus.sele, 4'b0001);
    d0 = doneCount;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t6_sele", bus.sele, 4'b0000);
    checkOutput("t6_blank", bus.blank, 0);
    checkOutput("t6_busy", bus.busy, 0);
    checkOutput("t6_done", bus.mode_done, 0);
    waitCycles(5);
    checkOutput("t6_done_count", doneCount - d0, 0);
    checkOutput("t6_frame_cnt", bus.frame_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
